drs_event_packer: RTL and testbench
===================================

# drs_event_packer

Downstream stage of the DRS readout block. It drains one event's byte stream from the DRS data FIFO read port and frames it into a self-describing packet: header, payload, trailer. The packet goes into the transmit byte FIFO that feeds the network sender. It runs in the FIFO read clock domain (CLK drives the DRS FIFO read clock) and reports completion to the trigger/state controller.

## Interface
- DEPTH_W, 13, width of READDEPTH
- TIMEOUT, 1024, payload cycles allowed with no DFIFO_VALID before abort
- MAGIC, 16'hA55A, header start word
- EOP, 8'hE5, final trailer byte
- CLK  in  1  clock; also the DRS FIFO read clock
- RST  in  1  reset, asynchronous, active-high
- READ_DONE  in  1  level from DRS readout; a rising edge starts one packet
- READDEPTH  in  13  samples per channel; sampled at start
- DFIFO_RD_EN  out  1  DRS FIFO read enable
- DFIFO_DOUT  in  8  DRS FIFO byte; MSB byte of each 16-bit word first
- DFIFO_EMPTY  in  1  DRS FIFO almost_empty (≤1 byte left)
- DFIFO_VALID  in  1  DFIFO_DOUT valid; one cycle after DFIFO_RD_EN
- TX_DATA  out  8  packet byte
- TX_WE  out  1  TX_DATA write strobe
- TX_AFULL  in  1  TX FIFO almost full; asserted with ≥4 free entries left
- PACK_BUSY  out  1  high from start until PACK_DONE
- PACK_DONE  out  1  one-cycle pulse after the last trailer byte
- EVT_NUM  out  32  number of the next packet to emit
- ERR_FLAGS  out  2  sticky {magic_err, timeout_err}; cleared at next start

## Operation
- Payload per event: PLEN = 4 + 4*READDEPTH bytes, computed in 16 bits at start. This is 2 + 2*READDEPTH 16-bit words: marker word 0xF00x, then the stop-channel/stop-cell word, then the samples of both channels.
- Packet layout:
  - Header, 8 bytes: MAGIC[15:8], MAGIC[7:0], EVT_NUM[31:24..7:0], PLEN[15:8], PLEN[7:0].
  - Payload: PLEN bytes.
  - Trailer, 2 bytes: {6'b0, ERR_FLAGS}, EOP.
- State IDLE: wait for a READ_DONE rising edge (registered edge detect).
  - On the edge: latch PLEN, clear ERR_FLAGS, set PACK_BUSY, go to HDR.
  - A READ_DONE edge while not in IDLE is ignored.
- State HDR: emit one header byte per cycle while TX_AFULL=0; hold while TX_AFULL=1. After byte 8, go to PAY.
- State PAY:
  - Read counter issue_c counts down from PLEN.
  - Assert DFIFO_RD_EN when all hold: issue_c>0, TX_AFULL=0, and (DFIFO_EMPTY=0 or issue_c==1).
  - Every DFIFO_VALID byte is forwarded: TX_DATA<=DFIFO_DOUT, TX_WE<=1 on the next cycle.
  - The first payload byte is checked: if it is not 8'hF0, set magic_err. The byte is forwarded anyway.
  - Leave PAY when the received count equals PLEN.
  - Timeout: if DFIFO_VALID stays low for TIMEOUT consecutive cycles, set timeout_err, stop reading, and go to TRL without padding.
- State TRL: emit the 2 trailer bytes, subject to TX_AFULL.
- State DONE: pulse PACK_DONE for one cycle, clear PACK_BUSY, increment EVT_NUM (wraps 0xFFFFFFFF→0), return to IDLE.
- READDEPTH=0 gives PLEN=4; this is legal.

## Timing
- Reset values: DFIFO_RD_EN=0, TX_WE=0, TX_DATA=0, PACK_BUSY=0, PACK_DONE=0, EVT_NUM=0, ERR_FLAGS=0, state IDLE.
- RST asserted mid-packet aborts immediately. No trailer is emitted. The FIFOs are reset by the same RST.
- READ_DONE edge to first TX_WE: 2 cycles.
- Payload byte latency: DFIFO_RD_EN → DFIFO_VALID (1 cycle) → TX_WE (1 cycle), giving 2 cycles total.
- Throughput: 1 byte/cycle with no back-pressure. Minimum packet duration is PLEN+10 cycles, plus 2 cycles of fill latency.
- TX_AFULL seen in cycle n: no new DFIFO_RD_EN or header/trailer byte in cycle n. At most 1 in-flight payload byte is still written after that, so the ≥4-entry margin is never exceeded.
- TX_AFULL coinciding with the last payload byte: the trailer waits; the byte is not lost.

## Structure
- Shared package drs_pack_pkg holds:
  - constants MAGIC, EOP, HDR_LEN=8, TRL_LEN=2, TIMEOUT;
  - the state encoding IDLE/HDR/PAY/TRL/DONE;
  - the PLEN function.
- No sub-module. A single FSM with issue/received counters and a byte mux.

## Test plan
- READDEPTH=4 with a preloaded 20-byte FIFO starting F0 01 … → exactly 30 TX_WE bytes: A5 5A 00 00 00 00 00 14, the 20 payload bytes, 00 E5. One PACK_DONE pulse follows, then EVT_NUM=1.
- TX_AFULL toggled every 3 cycles during a READDEPTH=1024 event (PLEN=4100) → all 4110 bytes are received in order, none dropped or duplicated, and the payload byte checksum matches.
- FIFO holds only 10 of 20 expected bytes → after TIMEOUT idle cycles, trailer is 01 E5, ERR_FLAGS=01, PACK_DONE pulses.
- First payload byte 0x12 → trailer flags byte is 02 and all bytes are still forwarded. The next event, with a correct first byte, gives ERR_FLAGS=00.
- EVT_NUM preset to 0xFFFFFFFF via 2^32 simulated packets (or a forced value) → header bytes are FF FF FF FF, then EVT_NUM=0.
- RST pulse during PAY → all outputs return to reset values within 1 cycle. The next READ_DONE edge produces a clean packet with EVT_NUM=0.

Source files
------------

// File: rtl/drs_pack_pkg.sv
// drs_pack_pkg: constants, state encoding and payload-length helper shared by the DRS event packer.
package drs_pack_pkg;
  localparam int DEPTH_W = 13;
  localparam int TIMEOUT = 1024;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0] MAGIC = 16'hA55A;
  localparam logic [7:0] EOP = 8'hE5;
  localparam logic [7:0] MARK = 8'hF0;
  localparam int HDR_LEN = 8;
  localparam int TRL_LEN = 2;
  typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, DONE} state_t;
  // Marker word + stop word + two channels of 16-bit samples.
  function automatic logic [15:0] plen(input logic [DEPTH_W-1:0] depth);
    return 16'd4 + {1'b0, depth, 2'b00};
  endfunction
endpackage

// File: rtl/drs_event_packer.sv
// drs_event_packer: drains one DRS event from the data FIFO and frames it as header/payload/trailer
// into the transmit byte FIFO, honouring TX almost-full back-pressure.
module drs_event_packer
  import drs_pack_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               READ_DONE,
  input  logic [DEPTH_W-1:0] READDEPTH,
  output logic               DFIFO_RD_EN,
  input  logic [7:0]         DFIFO_DOUT,
  input  logic               DFIFO_EMPTY,
  input  logic               DFIFO_VALID,
  output logic [7:0]         TX_DATA,
  output logic               TX_WE,
  input  logic               TX_AFULL,
  output logic               PACK_BUSY,
  output logic               PACK_DONE,
  output logic [31:0]        EVT_NUM,
  output logic [1:0]         ERR_FLAGS
);
  state_t state_q, state_d;
  logic rd_q, rise, tmo_hit;
  logic [15:0] plen_q, plen_d, issue_q, issue_d, rcv_q, rcv_d;
  logic [2:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0] err_q, err_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_we_q, tx_we_d;
  logic [31:0] evt_q;
  logic [63:0] hdr;

  assign rise = READ_DONE & ~rd_q;
  assign tmo_hit = state_q == PAY && !DFIFO_VALID && tmo_q == TMO_MAX;
  assign hdr = {MAGIC, evt_q, plen_q};

  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = rise ? HDR : IDLE;
      HDR:     state_d = (!TX_AFULL && idx_q == 3'(HDR_LEN - 1)) ? PAY : HDR;
      PAY:     state_d = (rcv_d == plen_q || tmo_hit) ? TRL : PAY;
      TRL:     state_d = (!TX_AFULL && idx_q == 3'(TRL_LEN - 1)) ? DONE : TRL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last byte may be fetched while the FIFO already reports almost-empty.
  always_comb begin
    DFIFO_RD_EN = state_q == PAY && issue_q != 16'd0 && !TX_AFULL &&
                  (!DFIFO_EMPTY || issue_q == 16'd1) && !tmo_hit;
    PACK_BUSY = state_q inside {HDR, PAY, TRL};
    PACK_DONE = state_q == DONE;
  end

  always_comb begin
    plen_d = plen_q;
    issue_d = issue_q;
    rcv_d = rcv_q;
    idx_d = idx_q;
    tmo_d = tmo_q;
    err_d = err_q;
    tx_we_d = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: if (rise) begin
        plen_d = plen(READDEPTH);
        issue_d = plen_d;
        rcv_d = '0;
        idx_d = '0;
        tmo_d = '0;
        err_d = '0;
      end
      HDR, TRL: if (!TX_AFULL) begin
        tx_we_d = 1'b1;
        tx_data_d = state_q == HDR ? 8'(hdr >> {~idx_q, 3'b000}) : idx_q[0] ? EOP : {6'b0, err_q};
        idx_d = idx_q + 3'd1;
      end
      PAY: begin
        issue_d = issue_q - 16'(DFIFO_RD_EN);
        tmo_d = DFIFO_VALID ? '0 : tmo_q + 1'b1;
        err_d[0] = err_q[0] | tmo_hit;
        if (DFIFO_VALID) begin
          tx_we_d = 1'b1;
          tx_data_d = DFIFO_DOUT;
          rcv_d = rcv_q + 16'd1;
          err_d[1] = err_q[1] | (rcv_q == 16'd0 && DFIFO_DOUT != MARK);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd_q <= 1'b0;
      plen_q <= '0;
      issue_q <= '0;
      rcv_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      err_q <= '0;
      tx_data_q <= '0;
      tx_we_q <= 1'b0;
    end else begin
      rd_q <= READ_DONE;
      plen_q <= plen_d;
      issue_q <= issue_d;
      rcv_q <= rcv_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      tx_data_q <= tx_data_d;
      tx_we_q <= tx_we_d;
    end

  always_ff @(posedge CLK or posedge RST)
    if (RST) evt_q <= '0;
    else if (state_q == DONE) evt_q <= evt_q + 32'd1;

  assign TX_DATA = tx_data_q;
  assign TX_WE = tx_we_q;
  assign EVT_NUM = evt_q;
  assign ERR_FLAGS = err_q;
endmodule

// File: tb/tb_drs_event_packer.sv
// tb_drs_event_packer: directed scenarios for the DRS event packer with a byte-FIFO source model.
module tb_drs_event_packer;
  logic CLK = 0, RST = 0, READ_DONE = 0, TX_AFULL = 0;
  logic [12:0] READDEPTH = '0;
  logic DFIFO_RD_EN, DFIFO_EMPTY, DFIFO_VALID, TX_WE, PACK_BUSY, PACK_DONE;
  logic [7:0] DFIFO_DOUT, TX_DATA;
  logic [31:0] EVT_NUM;
  logic [1:0] ERR_FLAGS;
  logic [7:0] mem [0:8191];
  logic [12:0] rp, wp = '0;
  logic [7:0] rx[$], exp_q[$];
  logic [1:0] af_h = '0;
  int n_cmp = 0, n_bad = 0, done_n = 0, af_viol = 0;

  always #5 CLK = ~CLK;

  drs_event_packer dut (
    .CLK(CLK), .RST(RST), .READ_DONE(READ_DONE), .READDEPTH(READDEPTH),
    .DFIFO_RD_EN(DFIFO_RD_EN), .DFIFO_DOUT(DFIFO_DOUT), .DFIFO_EMPTY(DFIFO_EMPTY),
    .DFIFO_VALID(DFIFO_VALID), .TX_DATA(TX_DATA), .TX_WE(TX_WE), .TX_AFULL(TX_AFULL),
    .PACK_BUSY(PACK_BUSY), .PACK_DONE(PACK_DONE), .EVT_NUM(EVT_NUM), .ERR_FLAGS(ERR_FLAGS)
  );

  always @(posedge CLK or posedge RST)
    if (RST) begin
      rp <= '0;
      DFIFO_VALID <= 1'b0;
      DFIFO_DOUT <= '0;
    end else begin
      DFIFO_VALID <= DFIFO_RD_EN && rp != wp;
      if (DFIFO_RD_EN && rp != wp) begin
        DFIFO_DOUT <= mem[rp];
        rp <= rp + 13'd1;
      end
    end
  assign DFIFO_EMPTY = 13'(wp - rp) <= 13'd1;

  always @(posedge CLK) af_h <= {af_h[0], TX_AFULL};
  always @(negedge CLK) begin
    if (TX_WE) rx.push_back(TX_DATA);
    if (PACK_DONE) done_n++;
    if (TX_WE && &af_h) af_viol++;
  end

  task automatic fifo_load(input int n, input logic [7:0] first, input int k, output logic [12:0] base);
    base = wp;
    for (int i = 0; i < n; i++) begin
      mem[wp] = (i == 0) ? first : 8'(i * k);
      wp = wp + 13'd1;
    end
  endtask

  task automatic build_exp(input logic [31:0] evt, input logic [15:0] pl, input logic [12:0] base,
                           input int n, input logic [1:0] fl);
    logic [63:0] h;
    h = {16'hA55A, evt, pl};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(h[63 - 8*i -: 8]);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[13'(base + i)]);
    exp_q.push_back({6'b0, fl});
    exp_q.push_back(8'hE5);
  endtask

  function automatic int count_diff();
    int d = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= rx.size() || rx[i] !== exp_q[i]) d++;
    return d + ((rx.size() > exp_q.size()) ? rx.size() - exp_q.size() : 0);
  endfunction

  task automatic kick();
    rx.delete();
    @(negedge CLK);
    READ_DONE = 1;
    @(negedge CLK);
    READ_DONE = 0;
  endtask

  task automatic wait_done(input int budget, input bit tog, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (tog && i % 3 == 2) TX_AFULL = ~TX_AFULL;
      if (PACK_DONE) ok = 1;
    end
    TX_AFULL = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    n_cmp++; if ({DFIFO_RD_EN, TX_WE, PACK_BUSY, PACK_DONE} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {DFIFO_RD_EN, TX_WE, PACK_BUSY, PACK_DONE}); end
    n_cmp++; if (TX_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", TX_DATA); end
    n_cmp++; if (EVT_NUM !== 32'd0) begin n_bad++; $display("FAIL reset_evt: got %h want 0", EVT_NUM); end
    n_cmp++; if (ERR_FLAGS !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", ERR_FLAGS); end
  endtask

  task automatic test_basic();
    logic [12:0] base;
    bit ok;
    int d0;
    fifo_load(20, 8'hF0, 1, base);
    READDEPTH = 13'd4;
    d0 = done_n;
    kick();
    n_cmp++; if ({PACK_BUSY, TX_WE} !== 2'b10) begin n_bad++; $display("FAIL start_busy: got %b want 10", {PACK_BUSY, TX_WE}); end
    @(negedge CLK);
    n_cmp++; if ({TX_WE, TX_DATA} !== 9'h1A5) begin n_bad++; $display("FAIL first_we: got %h want 1a5", {TX_WE, TX_DATA}); end
    wait_done(200, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done: no PACK_DONE within 200 cycles"); end
    build_exp(32'd0, 16'd20, base, 20, 2'b00);
    n_cmp++; if (rx.size() !== 30) begin n_bad++; $display("FAIL basic_len: got %0d want 30", rx.size()); end
    n_cmp++; if (count_diff() !== 0) begin n_bad++; $display("FAIL basic_bytes: got %0d bad bytes want 0", count_diff()); end
    n_cmp++; if (done_n - d0 !== 1 || PACK_DONE !== 1'b0 || PACK_BUSY !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %0d pulses done=%b busy=%b want 1/0/0", done_n - d0, PACK_DONE, PACK_BUSY); end
    n_cmp++; if (EVT_NUM !== 32'd1) begin n_bad++; $display("FAIL basic_evt: got %h want 1", EVT_NUM); end
  endtask

  task automatic test_magic();
    logic [12:0] base;
    bit ok;
    wp = rp;
    fifo_load(20, 8'h12, 3, base);
    READDEPTH = 13'd4;
    kick();
    wait_done(200, 0, ok);
    build_exp(32'd1, 16'd20, base, 20, 2'b10);
    n_cmp++; if (!ok || count_diff() !== 0) begin n_bad++; $display("FAIL magic_bytes: done=%b got %0d bad bytes want 0", ok, count_diff()); end
    n_cmp++; if (ERR_FLAGS !== 2'b10) begin n_bad++; $display("FAIL magic_err: got %b want 10", ERR_FLAGS); end
    wp = rp;
    fifo_load(20, 8'hF0, 5, base);
    kick();
    wait_done(200, 0, ok);
    build_exp(32'd2, 16'd20, base, 20, 2'b00);
    n_cmp++; if (!ok || count_diff() !== 0) begin n_bad++; $display("FAIL magic_next_bytes: done=%b got %0d bad bytes want 0", ok, count_diff()); end
    n_cmp++; if (ERR_FLAGS !== 2'b00) begin n_bad++; $display("FAIL magic_next_err: got %b want 00", ERR_FLAGS); end
  endtask

  task automatic test_timeout();
    logic [12:0] base;
    bit ok;
    wp = rp;
    fifo_load(10, 8'hF0, 7, base);
    READDEPTH = 13'd4;
    kick();
    wait_done(1400, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done: no PACK_DONE within 1400 cycles"); end
    // Almost-empty holds back the last buffered byte, so 9 of the 10 arrive.
    build_exp(32'd3, 16'd20, base, 9, 2'b01);
    n_cmp++; if (count_diff() !== 0) begin n_bad++; $display("FAIL tmo_bytes: got %0d bad bytes want 0", count_diff()); end
    n_cmp++; if (rx.size() < 2 || {rx[rx.size()-2], rx[rx.size()-1]} !== 16'h01E5) begin n_bad++; $display("FAIL tmo_trailer: got %0d bytes want trailer 01e5", rx.size()); end
    n_cmp++; if (ERR_FLAGS !== 2'b01) begin n_bad++; $display("FAIL tmo_err: got %b want 01", ERR_FLAGS); end
  endtask

  task automatic test_afull();
    logic [12:0] base;
    bit ok;
    int s_got, s_exp, v0;
    wp = rp;
    fifo_load(4100, 8'hF0, 13, base);
    READDEPTH = 13'd1024;
    v0 = af_viol;
    kick();
    wait_done(12000, 1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL af_done: no PACK_DONE within 12000 cycles"); end
    build_exp(32'd4, 16'd4100, base, 4100, 2'b00);
    n_cmp++; if (rx.size() !== 4110) begin n_bad++; $display("FAIL af_len: got %0d want 4110", rx.size()); end
    n_cmp++; if (count_diff() !== 0) begin n_bad++; $display("FAIL af_bytes: got %0d bad bytes want 0", count_diff()); end
    s_got = 0;
    s_exp = 0;
    for (int i = 0; i < 4100; i++) begin
      if (i + 8 < rx.size()) s_got += int'(rx[i + 8]);
      s_exp += int'(mem[13'(base + i)]);
    end
    n_cmp++; if (s_got !== s_exp) begin n_bad++; $display("FAIL af_sum: got %0d want %0d", s_got, s_exp); end
    n_cmp++; if (af_viol - v0 !== 0) begin n_bad++; $display("FAIL af_margin: got %0d late writes want 0", af_viol - v0); end
    n_cmp++; if (ERR_FLAGS !== 2'b00) begin n_bad++; $display("FAIL af_err: got %b want 00", ERR_FLAGS); end
  endtask

  task automatic test_rst_mid();
    logic [12:0] base;
    bit ok;
    wp = rp;
    fifo_load(20, 8'hF0, 1, base);
    READDEPTH = 13'd4;
    kick();
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      ok = rx.size() >= 12;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_reach_pay: got %0d bytes want 12", rx.size()); end
    #2 RST = 1;
    #1;
    n_cmp++; if ({DFIFO_RD_EN, TX_WE, PACK_BUSY, PACK_DONE} !== 4'b0 || TX_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_outputs: got %b/%h want 0000/00", {DFIFO_RD_EN, TX_WE, PACK_BUSY, PACK_DONE}, TX_DATA); end
    n_cmp++; if ({EVT_NUM, ERR_FLAGS} !== 34'd0) begin n_bad++; $display("FAIL rst_state: got %h/%b want 0/00", EVT_NUM, ERR_FLAGS); end
    @(negedge CLK);
    RST = 0;
    wp = '0;
    fifo_load(20, 8'hF0, 9, base);
    kick();
    wait_done(200, 0, ok);
    build_exp(32'd0, 16'd20, base, 20, 2'b00);
    n_cmp++; if (!ok || count_diff() !== 0) begin n_bad++; $display("FAIL rst_next_bytes: done=%b got %0d bad bytes want 0", ok, count_diff()); end
    n_cmp++; if (EVT_NUM !== 32'd1) begin n_bad++; $display("FAIL rst_next_evt: got %h want 1", EVT_NUM); end
  endtask

  task automatic test_wrap();
    logic [12:0] base;
    bit ok;
    @(negedge CLK);
    force dut.evt_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.evt_q;
    @(negedge CLK);
    n_cmp++; if (EVT_NUM !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preset: got %h want ffffffff", EVT_NUM); end
    wp = rp;
    fifo_load(4, 8'hF0, 0, base);
    READDEPTH = 13'd0;
    kick();
    wait_done(100, 0, ok);
    build_exp(32'hFFFF_FFFF, 16'd4, base, 4, 2'b00);
    n_cmp++; if (!ok || count_diff() !== 0) begin n_bad++; $display("FAIL wrap_bytes: done=%b got %0d bad bytes want 0", ok, count_diff()); end
    n_cmp++; if (EVT_NUM !== 32'd0) begin n_bad++; $display("FAIL wrap_evt: got %h want 0", EVT_NUM); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_magic();
    test_timeout();
    test_afull();
    test_rst_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
